// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access controller and MEM/WB stage register.
// It runs one req/ack data-memory transaction per load/store and stalls the
// upstream pipeline while the access is outstanding. It also registers the
// result (ALU value, load data, destination) into the write-back slot.
//
// Memory handshake: dmem_req is registered. It rises on the edge that leaves
// IDLE. addr/we/wdata are latched on that same edge and hold steady while
// req is high. The memory answers with a single-cycle dmem_ack; dmem_rdata is
// valid in that cycle. req drops on the edge that samples ack or that
// detects the timeout. The FSM always passes through DONE before it can
// raise req again, so req is never high for two back-to-back transactions.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_IDX_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_no_op,
  input  logic                     mem_reg_write_enable,
  input  logic [1:0]               mem_mem_control,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic [DATA_WIDTH-1:0]    mem_store_data,
  input  logic [REG_IDX_WIDTH-1:0] mem_dest_reg_idx,
  output logic                     mem_stall,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [DATA_WIDTH-1:0]    dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic                     wb_no_op,
  output logic                     wb_reg_write_enable,
  output logic                     wb_mem_read,
  output logic [DATA_WIDTH-1:0]    wb_alu_result,
  output logic [DATA_WIDTH-1:0]    wb_mem_read_data,
  output logic [REG_IDX_WIDTH-1:0] wb_dest_reg_idx,
  output logic                     wb_mem_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last BUSY count value before the transaction is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // state is kept as a named signal so checkers can bind to it directly.
  state_t                  state;
  state_t                  state_next;
  logic [7:0]              timeout_count;
  logic [DATA_WIDTH-1:0]   rdata_buf;
  logic                    error_bit;

  logic                    access;
  logic                    bad_access;
  logic                    start;
  logic                    timed_out;

  // Classify the instruction currently held in the MEM slot.
  always_comb begin
    access     = ~mem_no_op & (mem_mem_control != 2'b00);
    bad_access = (mem_alu_result[1:0] != 2'b00) | (mem_mem_control == 2'b11);
    start      = (state == IDLE) & access & ~bad_access;
    // An ack in the final cycle still wins over the timeout.
    timed_out  = (state == BUSY) & ~dmem_ack & (timeout_count == TIMEOUT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and combinational stall request.
  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mem_stall  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack || timed_out) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The WB slot takes the finished instruction on this edge and the
        // pipeline advances together with it.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory request channel, timeout counter, load buffer and error bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      timeout_count <= '0;
      rdata_buf     <= '0;
      error_bit     <= 1'b0;
    end else if (start) begin
      dmem_req      <= 1'b1;
      dmem_we       <= mem_mem_control[1];
      dmem_addr     <= {mem_alu_result[DATA_WIDTH-1:2], 2'b00};
      dmem_wdata    <= mem_store_data;
      timeout_count <= '0;
      rdata_buf     <= '0;
      error_bit     <= 1'b0;
    end else if (state == BUSY) begin
      if (dmem_ack) begin
        dmem_req  <= 1'b0;
        rdata_buf <= dmem_rdata;
      end else if (timed_out) begin
        dmem_req  <= 1'b0;
        error_bit <= 1'b1;
      end else begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end

  // MEM/WB stage register: bubble while stalled, completed access in DONE,
  // otherwise capture the MEM slot directly (ALU op, bubble or bad access).
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_no_op            <= 1'b1;
      wb_reg_write_enable <= 1'b0;
      wb_mem_read         <= 1'b0;
      wb_alu_result       <= '0;
      wb_mem_read_data    <= '0;
      wb_dest_reg_idx     <= '0;
      wb_mem_error        <= 1'b0;
    end else if (mem_stall) begin
      wb_no_op            <= 1'b1;
      wb_reg_write_enable <= 1'b0;
      wb_mem_read         <= 1'b0;
      wb_mem_error        <= 1'b0;
    end else if (state == DONE) begin
      wb_no_op            <= 1'b0;
      wb_reg_write_enable <= mem_reg_write_enable & ~error_bit;
      wb_mem_read         <= mem_mem_control[0];
      wb_alu_result       <= mem_alu_result;
      wb_mem_read_data    <= rdata_buf;
      wb_dest_reg_idx     <= mem_dest_reg_idx;
      wb_mem_error        <= error_bit;
    end else if (mem_no_op) begin
      wb_no_op            <= 1'b1;
      wb_reg_write_enable <= 1'b0;
      wb_mem_read         <= 1'b0;
      wb_mem_error        <= 1'b0;
    end else if (access) begin
      // Only bad accesses reach here: good ones raise mem_stall in IDLE.
      // No data comes back, so the read select stays low.
      wb_no_op            <= 1'b0;
      wb_reg_write_enable <= 1'b0;
      wb_mem_read         <= 1'b0;
      wb_alu_result       <= mem_alu_result;
      wb_dest_reg_idx     <= mem_dest_reg_idx;
      wb_mem_error        <= 1'b1;
    end else begin
      wb_no_op            <= 1'b0;
      wb_reg_write_enable <= mem_reg_write_enable;
      wb_mem_read         <= 1'b0;
      wb_alu_result       <= mem_alu_result;
      wb_dest_reg_idx     <= mem_dest_reg_idx;
      wb_mem_error        <= 1'b0;
    end
  end

endmodule
